// File: rtl/adaptive_box_track.sv
// rtl/adaptive_box_track.sv - per-field adaptive bounding box tracker around a supplied centroid
// Counts thresholded hits in an inner box and a guard ring, then grows/shrinks each axis once per field.
module adaptive_box_track #(
  parameter int          MAX_COL     = 720,
  parameter int          MAX_ROW     = 525,
  parameter int          INIT_W      = 150,
  parameter int          INIT_H      = 150,
  parameter int          MIN_W       = 20,
  parameter int          MAX_W       = 300,
  parameter int          MIN_H       = 20,
  parameter int          MAX_H       = 240,
  parameter int          STEP        = 10,
  parameter int          GUARD       = 30,
  parameter logic [7:0]  THRESH      = 8'hFF,
  parameter int          GROW_TOL    = 30,
  parameter int          SHRINK_TOL  = 10,
  parameter int          MIN_HITS    = 16,
  parameter int          LOST_FRAMES = 4,
  parameter int          CNT_W       = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       fvh,
  input  logic             dv,
  input  logic [7:0]       pixel,
  input  logic [10:0]      cx,
  input  logic [9:0]       cy,
  output logic [10:0]      half_w,
  output logic [9:0]       half_h,
  output logic [CNT_W-1:0] inner_count,
  output logic             update,
  output logic             lost
);

  typedef enum logic [1:0] {IDLE, ACCUM, UPDATE} state_t;

  localparam int               AW       = $clog2(LOST_FRAMES + 1);
  localparam logic [11:0]      XLIM     = 12'(MAX_COL - 1);
  localparam logic [11:0]      YLIM     = 12'(MAX_ROW - 1);
  localparam logic [11:0]      GRD      = 12'(GUARD);
  localparam logic [11:0]      STP      = 12'(STEP);
  localparam logic [CNT_W-1:0] CMAX     = '1;
  localparam logic [CNT_W-1:0] GROW_T   = CNT_W'(GROW_TOL);
  localparam logic [CNT_W-1:0] SHRINK_T = CNT_W'(SHRINK_TOL);
  localparam logic [CNT_W-1:0] HITS_T   = CNT_W'(MIN_HITS);
  localparam logic [AW-1:0]    LOSTN    = AW'(LOST_FRAMES);

  function automatic logic [11:0] lo_sat(input logic [11:0] c, input logic [11:0] h);
    return (c >= h) ? c - h : 12'd0;
  endfunction

  function automatic logic [11:0] hi_sat(input logic [11:0] c, input logic [11:0] h,
                                         input logic [11:0] lim);
    logic [12:0] s;
    s = {1'b0, c} + {1'b0, h};
    return (s > {1'b0, lim}) ? lim : s[11:0];
  endfunction

  function automatic logic [11:0] axis_step(input logic [11:0] cur, input logic [CNT_W-1:0] band,
                                            input logic [11:0] lo, input logic [11:0] hi);
    if (band >= GROW_T)   return (cur + STP > hi) ? hi : cur + STP;
    if (band < SHRINK_T)  return (cur < lo + STP) ? lo : cur - STP;
    return cur;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && v != CMAX) ? v + 1'b1 : v;
  endfunction

  state_t           state_q, state_d;
  logic             field_q, field_d;
  logic [9:0]       col_q, col_d, row_q, row_d;
  logic [11:0]      xlo_q, xlo_d, xhi_q, xhi_d, oxlo_q, oxlo_d, oxhi_q, oxhi_d;
  logic [11:0]      ylo_q, ylo_d, yhi_q, yhi_d, oylo_q, oylo_d, oyhi_q, oyhi_d;
  logic [CNT_W-1:0] inner_q, inner_d, bx_q, bx_d, by_q, by_d;
  logic [CNT_W-1:0] inner_count_q, inner_count_d;
  logic [10:0]      half_w_q, half_w_d;
  logic [9:0]       half_h_q, half_h_d;
  logic             update_q, update_d, lost_q, lost_d;
  logic [AW-1:0]    absent_q, absent_d, absent_nx;

  logic        frame_edge, active, hit, in_x, in_y, in_ox, in_oy, snap;
  logic [11:0] col12, row12, cx12, cy12, hw12, hh12;

  assign frame_edge = fvh[2] && !field_q;
  assign active     = dv && !fvh[2] && !fvh[1];
  assign hit        = active && (pixel >= THRESH);
  assign col12      = {2'b00, col_q};
  assign row12      = {2'b00, row_q};
  assign in_x       = (col12 >= xlo_q)  && (col12 <= xhi_q);
  assign in_y       = (row12 >= ylo_q)  && (row12 <= yhi_q);
  assign in_ox      = (col12 >= oxlo_q) && (col12 <= oxhi_q);
  assign in_oy      = (row12 >= oylo_q) && (row12 <= oyhi_q);

  always_comb begin
    state_d       = state_q;
    field_d       = fvh[2];
    col_d         = col_q;
    row_d         = row_q;
    xlo_d         = xlo_q;
    xhi_d         = xhi_q;
    oxlo_d        = oxlo_q;
    oxhi_d        = oxhi_q;
    ylo_d         = ylo_q;
    yhi_d         = yhi_q;
    oylo_d        = oylo_q;
    oyhi_d        = oyhi_q;
    inner_d       = inner_q;
    bx_d          = bx_q;
    by_d          = by_q;
    inner_count_d = inner_count_q;
    half_w_d      = half_w_q;
    half_h_d      = half_h_q;
    update_d      = 1'b0;
    lost_d        = lost_q;
    absent_d      = absent_q;
    absent_nx     = absent_q;
    snap          = 1'b0;
    cx12          = {1'b0, cx};
    cy12          = {2'b00, cy};
    hw12          = 12'd0;
    hh12          = 12'd0;

    if (fvh[0])      col_d = 10'd0;
    else if (active) col_d = (col_q == 10'd1023) ? 10'd1023 : col_q + 10'd1;
    if (fvh[1])                 row_d = 10'd0;
    else if (fvh[0] && !fvh[2]) row_d = (row_q > 10'd765) ? 10'd767 : row_q + 10'd2;

    case (state_q)
      IDLE: begin
        if (frame_edge) begin
          state_d = ACCUM;
          snap    = 1'b1;
        end
      end
      ACCUM: begin
        if (frame_edge) state_d = UPDATE;
        inner_d = sat_inc(inner_q, hit && in_x && in_y);
        bx_d    = sat_inc(bx_q, hit && in_ox && in_oy && !in_x);
        by_d    = sat_inc(by_q, hit && in_ox && in_oy && !in_y);
      end
      UPDATE: begin
        state_d       = ACCUM;
        snap          = 1'b1;
        update_d      = 1'b1;
        inner_count_d = inner_q;
        if (inner_q < HITS_T) begin
          absent_nx = (absent_q == LOSTN) ? absent_q : absent_q + 1'b1;
          absent_d  = absent_nx;
          if (absent_nx == LOSTN) begin
            lost_d   = 1'b1;
            half_w_d = 11'(INIT_W);
            half_h_d = 10'(INIT_H);
          end
        end else begin
          absent_d = '0;
          lost_d   = 1'b0;
          half_w_d = 11'(axis_step({1'b0, half_w_q}, bx_q, 12'(MIN_W), 12'(MAX_W)));
          half_h_d = 10'(axis_step({2'b00, half_h_q}, by_q, 12'(MIN_H), 12'(MAX_H)));
        end
      end
      default: state_d = IDLE;
    endcase

    // The box follows the half-sizes that become visible with this update.
    if (snap) begin
      hw12    = {1'b0, half_w_d};
      hh12    = {2'b00, half_h_d};
      xlo_d   = lo_sat(cx12, hw12);
      xhi_d   = hi_sat(cx12, hw12, XLIM);
      oxlo_d  = lo_sat(cx12, hw12 + GRD);
      oxhi_d  = hi_sat(cx12, hw12 + GRD, XLIM);
      ylo_d   = lo_sat(cy12, hh12);
      yhi_d   = hi_sat(cy12, hh12, YLIM);
      oylo_d  = lo_sat(cy12, hh12 + GRD);
      oyhi_d  = hi_sat(cy12, hh12 + GRD, YLIM);
      inner_d = '0;
      bx_d    = '0;
      by_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      field_q       <= 1'b0;
      col_q         <= '0;
      row_q         <= '0;
      xlo_q         <= '0;
      xhi_q         <= '0;
      oxlo_q        <= '0;
      oxhi_q        <= '0;
      ylo_q         <= '0;
      yhi_q         <= '0;
      oylo_q        <= '0;
      oyhi_q        <= '0;
      inner_q       <= '0;
      bx_q          <= '0;
      by_q          <= '0;
      inner_count_q <= '0;
      half_w_q      <= 11'(INIT_W);
      half_h_q      <= 10'(INIT_H);
      update_q      <= 1'b0;
      lost_q        <= 1'b0;
      absent_q      <= '0;
    end else begin
      state_q       <= state_d;
      field_q       <= field_d;
      col_q         <= col_d;
      row_q         <= row_d;
      xlo_q         <= xlo_d;
      xhi_q         <= xhi_d;
      oxlo_q        <= oxlo_d;
      oxhi_q        <= oxhi_d;
      ylo_q         <= ylo_d;
      yhi_q         <= yhi_d;
      oylo_q        <= oylo_d;
      oyhi_q        <= oyhi_d;
      inner_q       <= inner_d;
      bx_q          <= bx_d;
      by_q          <= by_d;
      inner_count_q <= inner_count_d;
      half_w_q      <= half_w_d;
      half_h_q      <= half_h_d;
      update_q      <= update_d;
      lost_q        <= lost_d;
      absent_q      <= absent_d;
    end
  end

  assign half_w      = half_w_q;
  assign half_h      = half_h_q;
  assign inner_count = inner_count_q;
  assign update      = update_q;
  assign lost        = lost_q;

endmodule

// File: tb/tb_adaptive_box_track.sv
// tb/tb_adaptive_box_track.sv - directed self-checking bench for adaptive_box_track
module tb_adaptive_box_track;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  fvh;
  logic        dv;
  logic [7:0]  pixel;
  logic [10:0] cx;
  logic [9:0]  cy;
  logic [10:0] half_w;
  logic [9:0]  half_h;
  logic [19:0] inner_count;
  logic        update;
  logic        lost;

  int tests = 0;
  int fails = 0;
  int cap_hw, cap_hh, cap_inner, cap_lost;
  int hw_e, hh_e, inner_e;

  always #5 clk = ~clk;

  adaptive_box_track dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .fvh         (fvh),
    .dv          (dv),
    .pixel       (pixel),
    .cx          (cx),
    .cy          (cy),
    .half_w      (half_w),
    .half_h      (half_h),
    .inner_count (inner_count),
    .update      (update),
    .lost        (lost)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [2:0] f, input logic d, input logic [7:0] p);
    fvh   = f;
    dv    = d;
    pixel = p;
    @(negedge clk);
  endtask

  // White (FF) inside either column range, just-below-threshold (FE) elsewhere, then hsync.
  task automatic line(input int lo1, input int hi1, input int lo2, input int hi2, input int ncols);
    for (int c = 0; c < ncols; c++)
      cyc(3'b000, 1'b1, ((c >= lo1 && c <= hi1) || (c >= lo2 && c <= hi2)) ? 8'hFF : 8'hFE);
    cyc(3'b001, 1'b0, 8'h00);
  endtask

  task automatic blank(input int n);
    for (int k = 0; k < n; k++) cyc(3'b001, 1'b0, 8'h00);
  endtask

  // 20x20 blob at cols 350..369, rows 230..268; optional 10x10 patch at cols 200..209.
  task automatic blob_frame(input logic guard);
    blank(115);
    for (int k = 0; k < 20; k++) begin
      if (guard && k < 10) line(200, 209, 350, 369, 370);
      else                 line(350, 369, -1, -1, 370);
    end
  endtask

  // Raise field for a bounded window, capture any update pulse, then open field 0.
  task automatic field_edge(input string tag, input int exp_pulses);
    int pulses;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(3'b100, 1'b0, 8'h00);
      if (update === 1'b1) begin
        pulses++;
        cap_hw    = int'(half_w);
        cap_hh    = int'(half_h);
        cap_inner = int'(inner_count);
        cap_lost  = int'(lost);
      end
    end
    chk({tag, "_update_pulses"}, pulses, exp_pulses);
    cyc(3'b011, 1'b0, 8'h00);
  endtask

  task automatic expect_upd(input string tag, input int inner, input int hw, input int hh,
                            input int lst);
    chk({tag, "_inner_count"}, cap_inner, inner);
    chk({tag, "_half_w"}, cap_hw, hw);
    chk({tag, "_half_h"}, cap_hh, hh);
    chk({tag, "_lost"}, cap_lost, lst);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_half_w"}, int'(half_w), 150);
    chk({tag, "_half_h"}, int'(half_h), 150);
    chk({tag, "_inner_count"}, int'(inner_count), 0);
    chk({tag, "_update"}, int'(update), 0);
    chk({tag, "_lost"}, int'(lost), 0);
  endtask

  initial begin
    reset_n = 1'b0;
    fvh = 3'b000; dv = 1'b0; pixel = 8'h00;
    cx = 11'd360; cy = 10'd240;
    cap_hw = -1; cap_hh = -1; cap_inner = -1; cap_lost = -1;
    repeat (3) @(negedge clk);
    check_reset("rst_init");
    reset_n = 1'b1;

    // Centred blob, empty guard: both axes shrink.
    field_edge("t2_arm", 0);
    blob_frame(1'b0);
    field_edge("t2", 1);
    expect_upd("t2", 400, 140, 140, 0);

    // Reset in the middle of a field.
    blank(50);
    line(350, 369, -1, -1, 370);
    reset_n = 1'b0;
    #1;
    check_reset("rst_mid");
    @(negedge clk);
    reset_n = 1'b1;

    // Left guard populated: X grows, Y shrinks.
    field_edge("t3_arm", 0);
    blob_frame(1'b1);
    field_edge("t3", 1);
    expect_upd("t3", 400, 160, 140, 0);

    // Full-white line at row 240: X grows to MAX_W and holds, Y shrinks to MIN_H and holds.
    hw_e = 160;
    hh_e = 140;
    for (int f = 0; f < 15; f++) begin
      blank(120);
      line(0, 719, -1, -1, 720);
      field_edge("t4", 1);
      inner_e = 2 * hw_e + 1;
      hw_e = (hw_e + 10 > 300) ? 300 : hw_e + 10;
      hh_e = (hh_e - 10 < 20) ? 20 : hh_e - 10;
      expect_upd("t4", inner_e, hw_e, hh_e, 0);
    end
    chk("t4_half_w_clamped", int'(half_w), 300);
    chk("t4_half_h_clamped", int'(half_h), 20);

    // Absent fields: hold for three, lost and reload on the fourth, stay lost on the fifth.
    for (int f = 0; f < 5; f++) begin
      blank(10);
      field_edge("t5_black", 1);
      if (f < 3) expect_upd("t5_hold", 0, 300, 20, 0);
      else       expect_upd("t5_lost", 0, 150, 150, 1);
    end
    blob_frame(1'b0);
    cx = 11'd5;
    cy = 10'd3;
    field_edge("t5_present", 1);
    expect_upd("t5_present", 400, 140, 140, 0);

    // Box near the origin: lower bounds clamp to 0; hits past the outer box are ignored.
    line(0, 3, 180, 183, 184);
    for (int k = 0; k < 3; k++) line(0, 3, -1, -1, 4);
    field_edge("t6_corner", 1);
    expect_upd("t6_corner", 16, 130, 130, 0);

    // One hit short of MIN_HITS counts as absent and holds the box.
    for (int k = 0; k < 3; k++) line(0, 4, -1, -1, 5);
    field_edge("t6_minhits", 1);
    expect_upd("t6_minhits", 15, 130, 130, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    fails++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
